load_store_buffer: RTL and testbench

- In-order load/store buffer for the Tomasulo RISC-V core.
- **Inputs:**
  - memory ops issued by the reorder buffer;
  - operands captured from the ROB commit broadcast.
- **Memory:** requests go to the memory controller one at a time.
- **Results:** load data and store completion go back to the ROB as finish pulses.
- **Commit rule:** stores write memory only after the ROB commits them.
- **Flush:** the buffer is flushed by the ROB exception line.

---
 rtl/load_store_buffer_pkg.sv | 21 ++
 rtl/load_store_buffer_align.sv | 22 ++
 rtl/load_store_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_buffer_pkg.sv
// load_store_buffer_pkg: shared opcodes, sizes, FSM states and entry layout for the load/store buffer
package load_store_buffer_pkg;
  localparam int XLEN = 32;
  localparam logic [5:0] OP_LB = 6'd0, OP_LH = 6'd1, OP_LW = 6'd2, OP_LBU = 6'd3, OP_LHU = 6'd4,
                         OP_SB = 6'd5, OP_SH = 6'd6, OP_SW = 6'd7;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_WAIT_COMMIT, ST_DRAIN} lsb_state_e;
  typedef struct packed {
    logic            valid;
    logic [5:0]      op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] q1;
    logic [XLEN-1:0] v2;
    logic [XLEN-1:0] q2;
    logic [XLEN-1:0] imm;
  } lsb_entry_t;
  function automatic logic is_store(input logic [5:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction
endpackage

// File: rtl/load_store_buffer_align.sv
// load_store_align: access size, store lane selection and load sign/zero extension from the opcode
module load_store_align
  import load_store_buffer_pkg::*;
(
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] store_in,
  input  logic [XLEN-1:0] load_in,
  output logic [1:0]      size,
  output logic [XLEN-1:0] store_out,
  output logic [XLEN-1:0] load_out
);
  always_comb begin
    size = (op == OP_LB || op == OP_LBU || op == OP_SB) ? SZ_B :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_H : SZ_W;
    store_out = size == SZ_B ? {{(XLEN-8){1'b0}}, store_in[7:0]} :
                size == SZ_H ? {{(XLEN-16){1'b0}}, store_in[15:0]} : store_in;
    load_out = op == OP_LB  ? {{(XLEN-8){load_in[7]}}, load_in[7:0]} :
               op == OP_LH  ? {{(XLEN-16){load_in[15]}}, load_in[15:0]} :
               op == OP_LBU ? {{(XLEN-8){1'b0}}, load_in[7:0]} :
               op == OP_LHU ? {{(XLEN-16){1'b0}}, load_in[15:0]} : load_in;
  end
endmodule

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store FIFO that issues the head entry to memory, holding stores until commit
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_exception_from_rob,
  input  logic            is_empty_from_rob,
  input  logic            is_sl_from_rob,
  input  logic [5:0]      op_from_rob,
  input  logic [XLEN-1:0] pc_from_rob,
  input  logic [XLEN-1:0] v1_from_rob,
  input  logic [XLEN-1:0] v2_from_rob,
  input  logic [XLEN-1:0] imm_from_rob,
  input  logic [XLEN-1:0] q1_from_rob,
  input  logic [XLEN-1:0] q2_from_rob,
  input  logic            is_commit_from_rob,
  input  logic [XLEN-1:0] commit_pc_from_rob,
  input  logic [XLEN-1:0] commit_data_from_rob,
  output logic            is_full_to_rob,
  output logic            is_finish_to_rob,
  output logic [XLEN-1:0] pc_to_rob,
  output logic [XLEN-1:0] data_to_rob,
  output logic            is_req_to_mc,
  output logic            is_write_to_mc,
  output logic [1:0]      size_to_mc,
  output logic [XLEN-1:0] addr_to_mc,
  output logic [XLEN-1:0] data_to_mc,
  input  logic            is_done_from_mc,
  input  logic [XLEN-1:0] data_from_mc
);
  lsb_entry_t buf_q [DEPTH];
  lsb_entry_t buf_d [DEPTH];
  lsb_entry_t head;
  lsb_state_e state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0] count_q, count_d;
  logic req_q, req_d, write_q, write_d, finish_q, finish_d;
  logic [1:0] size_q, size_d, head_size;
  logic [XLEN-1:0] addr_q, addr_d, mdata_q, mdata_d, rpc_q, rpc_d, rdata_q, rdata_d;
  logic [XLEN-1:0] head_sdata, head_ldata;
  logic dispatch, push, pop, keep, head_ready, commit_hit;

  assign head       = buf_q[head_q];
  assign head_ready = head.valid && head.q1 == '0 && head.q2 == '0;
  assign commit_hit = is_commit_from_rob && commit_pc_from_rob == head.pc;
  assign dispatch   = !is_empty_from_rob && is_sl_from_rob;
  assign push       = dispatch && !is_exception_from_rob && count_q != (PTR_W+1)'(DEPTH);

  load_store_align u_align (
    .op        (head.op),
    .store_in  (head.v2),
    .load_in   (data_from_mc),
    .size      (head_size),
    .store_out (head_sdata),
    .load_out  (head_ldata)
  );

  always_comb begin
    buf_d    = buf_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    state_d  = state_q;
    req_d    = req_q;
    write_d  = write_q;
    size_d   = size_q;
    addr_d   = addr_q;
    mdata_d  = mdata_q;
    finish_d = 1'b0;
    rpc_d    = rpc_q;
    rdata_d  = rdata_q;
    pop      = 1'b0;
    keep     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (buf_q[i].valid && is_commit_from_rob && buf_q[i].q1 != '0 && buf_q[i].q1 == commit_pc_from_rob) begin
        buf_d[i].v1 = commit_data_from_rob;
        buf_d[i].q1 = '0;
      end
      if (buf_q[i].valid && is_commit_from_rob && buf_q[i].q2 != '0 && buf_q[i].q2 == commit_pc_from_rob) begin
        buf_d[i].v2 = commit_data_from_rob;
        buf_d[i].q2 = '0;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (!is_exception_from_rob && head_ready && is_store(head.op)) begin
          finish_d = 1'b1;
          rpc_d    = head.pc;
          rdata_d  = '0;
          state_d  = ST_WAIT_COMMIT;
        end else if (!is_exception_from_rob && head_ready) begin
          req_d   = 1'b1;
          write_d = 1'b0;
          size_d  = head_size;
          addr_d  = head.v1 + head.imm;
          mdata_d = '0;
          state_d = ST_MEM;
        end
      end
      ST_WAIT_COMMIT: begin
        if (commit_hit) begin
          req_d   = 1'b1;
          write_d = 1'b1;
          size_d  = head_size;
          addr_d  = head.v1 + head.imm;
          mdata_d = head_sdata;
          state_d = ST_MEM;
        end else if (is_exception_from_rob) begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        if (is_done_from_mc) begin
          req_d   = 1'b0;
          pop     = 1'b1;
          state_d = ST_IDLE;
          finish_d = !write_q && !is_exception_from_rob;
          rpc_d    = finish_d ? head.pc : rpc_q;
          rdata_d  = finish_d ? head_ldata : rdata_q;
        end else if (is_exception_from_rob && !write_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        req_d   = is_done_from_mc ? 1'b0 : req_q;
        state_d = is_done_from_mc ? ST_IDLE : ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      buf_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    if (is_exception_from_rob) begin
      // a store whose commit was already seen must still reach memory
      keep = (state_q == ST_WAIT_COMMIT && commit_hit) || (state_q == ST_MEM && write_q && !is_done_from_mc);
      for (int i = 0; i < DEPTH; i++)
        if (!(keep && PTR_W'(i) == head_q)) buf_d[i].valid = 1'b0;
      head_d  = (state_q == ST_MEM && !write_q) ? head_q + PTR_W'(1) : head_d;
      tail_d  = keep ? head_q + PTR_W'(1) : head_d;
      count_d = (PTR_W+1)'(keep);
    end else begin
      if (push) begin
        buf_d[tail_q].valid = 1'b1;
        buf_d[tail_q].op    = op_from_rob;
        buf_d[tail_q].pc    = pc_from_rob;
        buf_d[tail_q].imm   = imm_from_rob;
        buf_d[tail_q].v1    = (is_commit_from_rob && q1_from_rob != '0 && q1_from_rob == commit_pc_from_rob) ? commit_data_from_rob : v1_from_rob;
        buf_d[tail_q].q1    = (is_commit_from_rob && q1_from_rob == commit_pc_from_rob) ? '0 : q1_from_rob;
        buf_d[tail_q].v2    = (is_commit_from_rob && q2_from_rob != '0 && q2_from_rob == commit_pc_from_rob) ? commit_data_from_rob : v2_from_rob;
        buf_d[tail_q].q2    = (is_commit_from_rob && q2_from_rob == commit_pc_from_rob) ? '0 : q2_from_rob;
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      state_q  <= ST_IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      mdata_q  <= '0;
      finish_q <= 1'b0;
      rpc_q    <= '0;
      rdata_q  <= '0;
    end else begin
      buf_q    <= buf_d;
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      req_q    <= req_d;
      write_q  <= write_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      mdata_q  <= mdata_d;
      finish_q <= finish_d;
      rpc_q    <= rpc_d;
      rdata_q  <= rdata_d;
    end
  end

  assign is_full_to_rob   = count_q >= (PTR_W+1)'(DEPTH - 1);
  assign is_finish_to_rob = finish_q;
  assign pc_to_rob        = rpc_q;
  assign data_to_rob      = rdata_q;
  assign is_req_to_mc     = req_q;
  assign is_write_to_mc   = write_q;
  assign size_to_mc       = size_q;
  assign addr_to_mc       = addr_q;
  assign data_to_mc       = mdata_q;

  assert property (@(posedge clk) disable iff (rst) !(dispatch && !is_exception_from_rob && count_q == (PTR_W+1)'(DEPTH)));
endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer: directed checks of load, store gating, wakeup, full/wrap, flush and async reset
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic is_exception_from_rob = 0, is_empty_from_rob = 1, is_sl_from_rob = 0;
  logic [5:0] op_from_rob = '0;
  logic [31:0] pc_from_rob = '0, v1_from_rob = '0, v2_from_rob = '0, imm_from_rob = '0;
  logic [31:0] q1_from_rob = '0, q2_from_rob = '0;
  logic is_commit_from_rob = 0;
  logic [31:0] commit_pc_from_rob = '0, commit_data_from_rob = '0;
  logic is_full_to_rob, is_finish_to_rob, is_req_to_mc, is_write_to_mc;
  logic [31:0] pc_to_rob, data_to_rob, addr_to_mc, data_to_mc;
  logic [1:0] size_to_mc;
  logic is_done_from_mc = 0;
  logic [31:0] data_from_mc = '0;
  int checks = 0, failures = 0;

  load_store_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .is_exception_from_rob(is_exception_from_rob), .is_empty_from_rob(is_empty_from_rob),
    .is_sl_from_rob(is_sl_from_rob), .op_from_rob(op_from_rob), .pc_from_rob(pc_from_rob),
    .v1_from_rob(v1_from_rob), .v2_from_rob(v2_from_rob), .imm_from_rob(imm_from_rob),
    .q1_from_rob(q1_from_rob), .q2_from_rob(q2_from_rob),
    .is_commit_from_rob(is_commit_from_rob), .commit_pc_from_rob(commit_pc_from_rob),
    .commit_data_from_rob(commit_data_from_rob),
    .is_full_to_rob(is_full_to_rob), .is_finish_to_rob(is_finish_to_rob),
    .pc_to_rob(pc_to_rob), .data_to_rob(data_to_rob),
    .is_req_to_mc(is_req_to_mc), .is_write_to_mc(is_write_to_mc), .size_to_mc(size_to_mc),
    .addr_to_mc(addr_to_mc), .data_to_mc(data_to_mc),
    .is_done_from_mc(is_done_from_mc), .data_from_mc(data_from_mc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] pc, v1, v2, imm, q1);
    op_from_rob = op; pc_from_rob = pc; v1_from_rob = v1; v2_from_rob = v2;
    imm_from_rob = imm; q1_from_rob = q1; q2_from_rob = '0;
    is_sl_from_rob = 1; is_empty_from_rob = 0;
    @(negedge clk);
    is_sl_from_rob = 0; is_empty_from_rob = 1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] data);
    is_commit_from_rob = 1; commit_pc_from_rob = pc; commit_data_from_rob = data;
    @(negedge clk);
    is_commit_from_rob = 0;
  endtask

  task automatic mem_done(input logic [31:0] data);
    is_done_from_mc = 1; data_from_mc = data;
    @(negedge clk);
    is_done_from_mc = 0;
  endtask

  task automatic flush();
    is_exception_from_rob = 1;
    @(negedge clk);
    is_exception_from_rob = 0;
  endtask

  task automatic wait_req(input string tag);
    for (int n = 0; n < 20 && !is_req_to_mc; n++) @(negedge clk);
    check(tag, 32'(is_req_to_mc), 1);
  endtask

  initial begin
    @(negedge clk);
    check("rst_req", 32'(is_req_to_mc), 0);
    check("rst_finish", 32'(is_finish_to_rob), 0);
    check("rst_full", 32'(is_full_to_rob), 0);
    rst = 0;
    @(negedge clk);
    // LW: request one cycle after the dispatch edge
    dispatch(OP_LW, 32'h10, 32'h100, 0, 4, 0);
    check("lw_req_early", 32'(is_req_to_mc), 0);
    @(negedge clk);
    check("lw_req", 32'(is_req_to_mc), 1);
    check("lw_addr", addr_to_mc, 32'h104);
    check("lw_size", 32'(size_to_mc), 2);
    check("lw_write", 32'(is_write_to_mc), 0);
    @(negedge clk);
    check("lw_hold_addr", addr_to_mc, 32'h104);
    mem_done(32'hDEADBEEF);
    check("lw_finish", 32'(is_finish_to_rob), 1);
    check("lw_pc", pc_to_rob, 32'h10);
    check("lw_data", data_to_rob, 32'hDEADBEEF);
    check("lw_req_drop", 32'(is_req_to_mc), 0);
    @(negedge clk);
    check("lw_finish_pulse", 32'(is_finish_to_rob), 0);
    // SB: finish first, write only after matching commit
    dispatch(OP_SB, 32'h30, 32'h200, 32'h1234AB, 0, 0);
    @(negedge clk);
    check("sb_finish", 32'(is_finish_to_rob), 1);
    check("sb_pc", pc_to_rob, 32'h30);
    check("sb_fdata", data_to_rob, 0);
    check("sb_noreq", 32'(is_req_to_mc), 0);
    commit(32'h99, 32'h0);
    @(negedge clk);
    check("sb_noreq_other", 32'(is_req_to_mc), 0);
    check("sb_finish_once", 32'(is_finish_to_rob), 0);
    commit(32'h30, 32'h0);
    check("sb_req", 32'(is_req_to_mc), 1);
    check("sb_write", 32'(is_write_to_mc), 1);
    check("sb_addr", addr_to_mc, 32'h200);
    check("sb_size", 32'(size_to_mc), 0);
    check("sb_wdata", data_to_mc, 32'hAB);
    mem_done(32'h0);
    check("sb_nofinish", 32'(is_finish_to_rob), 0);
    check("sb_req_drop", 32'(is_req_to_mc), 0);
    // LB waiting on a producer, then LBU / LH ready
    dispatch(OP_LB, 32'h40, 0, 0, 8, 32'h20);
    @(negedge clk);
    check("lb_wait", 32'(is_req_to_mc), 0);
    commit(32'h20, 32'h300);
    wait_req("lb_req");
    check("lb_addr", addr_to_mc, 32'h308);
    check("lb_size", 32'(size_to_mc), 0);
    mem_done(32'h80);
    check("lb_finish", 32'(is_finish_to_rob), 1);
    check("lb_data", data_to_rob, 32'hFFFFFF80);
    dispatch(OP_LBU, 32'h50, 32'h300, 0, 8, 0);
    wait_req("lbu_req");
    mem_done(32'h80);
    check("lbu_data", data_to_rob, 32'h80);
    dispatch(OP_LH, 32'h58, 32'h310, 0, 2, 0);
    wait_req("lh_req");
    check("lh_addr", addr_to_mc, 32'h312);
    check("lh_size", 32'(size_to_mc), 1);
    mem_done(32'h8001);
    check("lh_data", data_to_rob, 32'hFFFF8001);
    // seven blocked loads fill the buffer and wrap across index 7 -> 0
    for (int i = 0; i < 7; i++) begin
      dispatch(OP_LW, 32'h100 + 32'(i), 0, 0, 32'(i) * 4, 32'h77);
      if (i == 5) check("full_at6", 32'(is_full_to_rob), 0);
    end
    check("full_at7", 32'(is_full_to_rob), 1);
    check("full_noreq", 32'(is_req_to_mc), 0);
    commit(32'h77, 32'h1000);
    for (int i = 0; i < 7; i++) begin
      wait_req("wrap_req");
      check("wrap_addr", addr_to_mc, 32'h1000 + 32'(i) * 4);
      mem_done(32'(i));
      check("wrap_pc", pc_to_rob, 32'h100 + 32'(i));
      if (i == 0) check("full_after_pop", 32'(is_full_to_rob), 0);
    end
    // flush while a load is in MEM
    dispatch(OP_LW, 32'h60, 32'h500, 0, 0, 0);
    dispatch(OP_LW, 32'h64, 32'h640, 0, 0, 0);
    wait_req("fl_req");
    check("fl_addr", addr_to_mc, 32'h500);
    flush();
    check("fl_finish", 32'(is_finish_to_rob), 0);
    check("fl_hold", 32'(is_req_to_mc), 1);
    @(negedge clk);
    check("fl_hold_addr", addr_to_mc, 32'h500);
    mem_done(32'h1234);
    check("fl_nofinish", 32'(is_finish_to_rob), 0);
    check("fl_req_drop", 32'(is_req_to_mc), 0);
    repeat (2) @(negedge clk);
    check("fl_empty", 32'(is_req_to_mc), 0);
    dispatch(OP_LW, 32'h70, 32'h700, 0, 0, 0);
    wait_req("fl_new_req");
    check("fl_new_addr", addr_to_mc, 32'h700);
    mem_done(32'h5);
    check("fl_new_pc", pc_to_rob, 32'h70);
    // flush while a committed store is in MEM
    dispatch(OP_SW, 32'h80, 32'h800, 32'hCAFEF00D, 0, 0);
    @(negedge clk);
    check("fs_finish", 32'(is_finish_to_rob), 1);
    dispatch(OP_LW, 32'h84, 32'h840, 0, 0, 0);
    commit(32'h80, 32'h0);
    check("fs_req", 32'(is_write_to_mc), 1);
    flush();
    check("fs_hold", 32'(is_req_to_mc), 1);
    check("fs_addr", addr_to_mc, 32'h800);
    check("fs_wdata", data_to_mc, 32'hCAFEF00D);
    mem_done(32'h0);
    check("fs_req_drop", 32'(is_req_to_mc), 0);
    repeat (3) @(negedge clk);
    check("fs_younger_gone", 32'(is_req_to_mc), 0);
    check("fs_not_full", 32'(is_full_to_rob), 0);
    // asynchronous reset mid-MEM
    dispatch(OP_LW, 32'h90, 32'h900, 0, 0, 0);
    wait_req("ar_req");
    #2 rst = 1;
    #1;
    check("ar_req", 32'(is_req_to_mc), 0);
    check("ar_addr", addr_to_mc, 0);
    check("ar_pc", pc_to_rob, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    check("ar_idle", 32'(is_req_to_mc), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
